// File: rtl/eeprom_slave_model.sv
// eeprom_slave_model: two-wire serial EEPROM slave (byte write, random read, sequential read) with open-drain SDA.
`timescale 1ns/1ps
module eeprom_slave_model #(
    parameter int         ADDR_W = 11,
    parameter logic [3:0] DEV_ID = 4'b1010
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SCL,
    inout  wire  SDA,
    output logic BUSY,
    output logic WR_DONE
);
    typedef enum logic [3:0] {
        IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;
    state_t state_q, state_d;
    logic [1:0] scl_sync_q, sda_sync_q;
    logic scl_prev_q, sda_prev_q;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic rw_q, rw_d, oe_q, oe_d, busy_q, busy_d, wr_done_q, wr_done_d, mem_we;
    logic [7:0] mem [2**ADDR_W];
    logic scl, sda, scl_rise, scl_fall, start, stop, last_bit, id_ok;
    logic [7:0] byte_in, rd_byte;
    assign scl      = scl_sync_q[1];
    assign sda      = sda_sync_q[1];
    assign scl_rise = scl & ~scl_prev_q;
    assign scl_fall = ~scl & scl_prev_q;
    assign start    = scl & scl_prev_q & sda_prev_q & ~sda;
    assign stop     = scl & scl_prev_q & ~sda_prev_q & sda;
    assign byte_in  = {sh_q[6:0], sda};
    assign last_bit = cnt_q == 4'd7;
    assign id_ok    = byte_in[7:4] == DEV_ID;
    assign rd_byte  = mem[addr_q];
    assign SDA      = oe_q ? 1'b0 : 1'bz;
    assign BUSY     = busy_q;
    assign WR_DONE  = wr_done_q;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            wr_done_q  <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], SCL};
            sda_sync_q <= {sda_sync_q[0], SDA};
            scl_prev_q <= scl;
            sda_prev_q <= sda;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            wr_done_q  <= wr_done_d;
        end
    end
    // The array has no reset so its contents survive RESET.
    always_ff @(posedge CLK) begin
        if (mem_we) mem[addr_q] <= byte_in;
    end
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        wr_done_d = 1'b0;
        mem_we    = 1'b0;
        if (start) begin
            state_d = CTRL;
            cnt_d   = '0;
            busy_d  = 1'b1;
            oe_d    = 1'b0;
        end else if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                CTRL: if (scl_rise) begin
                    sh_d  = byte_in;
                    cnt_d = cnt_q + 4'd1;
                    if (last_bit) begin
                        cnt_d   = '0;
                        state_d = id_ok ? CTRL_ACK : IDLE;
                        busy_d  = id_ok;
                        rw_d    = byte_in[0];
                        if (id_ok && !byte_in[0]) addr_d = ADDR_W'({byte_in[3:1], addr_q[7:0]});
                    end
                end
                ADDR, WDATA: if (scl_rise) begin
                    sh_d  = byte_in;
                    cnt_d = cnt_q + 4'd1;
                    if (last_bit) begin
                        cnt_d = '0;
                        if (state_q == ADDR) begin
                            addr_d[7:0] = byte_in;
                            state_d     = ADDR_ACK;
                        end else begin
                            mem_we    = 1'b1;
                            wr_done_d = 1'b1;
                            state_d   = WDATA_ACK;
                        end
                    end
                end
                // First SCL fall asserts the ACK, second fall releases it and moves on.
                CTRL_ACK, ADDR_ACK, WDATA_ACK: if (scl_fall) begin
                    oe_d  = cnt_q == 4'd0;
                    cnt_d = (cnt_q == 4'd0) ? 4'd1 : 4'd0;
                    if (cnt_q != 4'd0) begin
                        state_d = (state_q == CTRL_ACK) ? (rw_q ? RDATA : ADDR) : WDATA;
                        if (state_q == WDATA_ACK) addr_d = addr_q + ADDR_W'(1);
                        if (state_q == CTRL_ACK && rw_q) begin
                            sh_d = {rd_byte[6:0], 1'b0};
                            oe_d = ~rd_byte[7];
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) cnt_d = cnt_q + 4'd1;
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            cnt_d   = '0;
                            state_d = RDATA_ACK;
                        end else begin
                            oe_d = ~sh_q[7];
                            sh_d = {sh_q[6:0], 1'b0};
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise && cnt_q == 4'd0) begin
                        addr_d = addr_q + ADDR_W'(1);
                        cnt_d  = sda ? 4'd0 : 4'd1;
                        if (sda) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                    if (scl_fall && cnt_q == 4'd1) begin
                        state_d = RDATA;
                        cnt_d   = '0;
                        sh_d    = {rd_byte[6:0], 1'b0};
                        oe_d    = ~rd_byte[7];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eeprom_slave_model.sv
// tb_eeprom_slave_model: bus-master driver, reference memory model and scoreboard for eeprom_slave_model.
`timescale 1ns/1ps
module tb_eeprom_slave_model;
    localparam int Q = 50;
    logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_low = 1'b0;
    logic busy, wr_done;
    wire  sda_bus;
    int   slot = 0;
    int   n_cmp = 0, n_err = 0, wr_pending = 0;
    logic [7:0] exp_q[$];
    logic [7:0] wq[$];
    logic [7:0] ref_mem[2048];
    bit         vld[2048];
    int         wr_list[$];

    always #5 clk = ~clk;
    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    eeprom_slave_model dut (.CLK(clk), .RESET(rst_n), .SCL(scl), .SDA(sda_bus), .BUSY(busy), .WR_DONE(wr_done));

    function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboard monitor: samples SDA mid-high on slave-driven clocks and pops the expected value.
    initial begin
        int k, nb;
        logic [7:0] acc, e;
        nb = 0;
        acc = '0;
        forever begin
            @(posedge scl);
            k = slot;
            #(Q);
            if (k == 2) begin
                acc = {acc[6:0], sda_bus};
                nb++;
            end
            if (k == 1 || (k == 2 && nb == 8)) begin
                nb = 0;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL scoreboard_underflow: got slave output with no expected entry at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check(k == 1 ? "ack_bit" : "read_byte", k == 1 ? {7'd0, sda_bus} : acc, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (wr_done === 1'b1) begin
            n_cmp++;
            if (wr_pending == 0) begin
                n_err++;
                $display("FAIL wr_done_unexpected: got pulse expected none at %0t", $time);
            end else wr_pending--;
        end
    end

    task automatic bit_tx(input logic b, input int kind);
        m_low = ~b;
        slot = kind;
        #(Q); scl = 1'b1;
        #(2*Q); scl = 1'b0;
        #(Q);
    endtask

    task automatic start_c();
        m_low = 1'b0; slot = 0;
        #(Q); scl = 1'b1;
        #(Q); m_low = 1'b1;
        #(Q); scl = 1'b0;
        #(Q);
    endtask

    task automatic stop_c();
        m_low = 1'b1; slot = 0;
        #(Q); scl = 1'b1;
        #(Q); m_low = 1'b0;
        #(2*Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack_exp);
        for (int i = 7; i >= 0; i--) bit_tx(b[i], 0);
        exp_q.push_back({7'd0, ack_exp});
        bit_tx(1'b1, 1);
    endtask

    task automatic recv_byte(input logic [7:0] e, input logic nack);
        exp_q.push_back(e);
        for (int i = 0; i < 8; i++) bit_tx(1'b1, 2);
        bit_tx(nack, 0);
    endtask

    task automatic check_end();
        check("busy_after_stop", {7'd0, busy}, 8'd0);
        check("wr_done_outstanding", 8'(wr_pending), 8'd0);
        check("scoreboard_leftover", 8'(exp_q.size()), 8'd0);
    endtask

    task automatic write_txn(input logic [10:0] a);
        logic [10:0] p;
        p = a;
        start_c();
        check("busy_after_start", {7'd0, busy}, 8'd1);
        send_byte({4'hA, a[10:8], 1'b0}, 1'b0);
        send_byte(a[7:0], 1'b0);
        foreach (wq[i]) begin
            wr_pending++;
            send_byte(wq[i], 1'b0);
            ref_mem[p] = wq[i];
            if (!vld[p]) begin
                vld[p] = 1'b1;
                wr_list.push_back(int'(p));
            end
            p = p + 11'd1;
        end
        stop_c();
        check_end();
    endtask

    task automatic read_txn(input logic [10:0] a, input int n);
        start_c();
        send_byte({4'hA, a[10:8], 1'b0}, 1'b0);
        send_byte(a[7:0], 1'b0);
        start_c();
        send_byte({4'hA, a[10:8], 1'b1}, 1'b0);
        for (int i = 0; i < n; i++) begin
            recv_byte(ref_mem[a], i == n - 1);
            a = a + 11'd1;
        end
        stop_c();
        check_end();
    endtask

    task automatic bad_txn(input logic [7:0] ctrl, input int extra);
        start_c();
        send_byte(ctrl, 1'b1);
        for (int i = 0; i < extra; i++) send_byte(8'($urandom), 1'b1);
        stop_c();
        check_end();
    endtask

    initial begin
        #23;
        check("reset_busy", {7'd0, busy}, 8'd0);
        check("reset_wr_done", {7'd0, wr_done}, 8'd0);
        check("reset_sda", {7'd0, sda_bus}, 8'd1);
        rst_n = 1'b1;
        #100;
        wq = '{8'h5A};
        write_txn(11'h3C5);
        read_txn(11'h3C5, 1);
        bad_txn(8'hB6, 2);
        wq = '{8'h11, 8'h22};
        write_txn(11'h7FF);
        read_txn(11'h7FF, 2);
        // Aborted write: four data bits then STOP.
        start_c();
        send_byte(8'hA6, 1'b0);
        send_byte(8'hC5, 1'b0);
        for (int i = 0; i < 4; i++) bit_tx(1'($urandom), 0);
        stop_c();
        check_end();
        read_txn(11'h3C5, 1);
        // Reset while the slave pulls SDA low for bit 7 of 0x5A.
        start_c();
        send_byte(8'hA6, 1'b0);
        send_byte(8'hC5, 1'b0);
        start_c();
        send_byte(8'hA7, 1'b0);
        check("read_msb_driven_low", {7'd0, sda_bus}, 8'd0);
        #4 rst_n = 1'b0;
        #2;
        check("sda_released_on_reset", {7'd0, sda_bus}, 8'd1);
        check("busy_on_reset", {7'd0, busy}, 8'd0);
        #30 rst_n = 1'b1;
        #20;
        stop_c();
        read_txn(11'h3C5, 1);
        for (int t = 0; t < 30; t++) begin
            int r, n;
            logic [10:0] a;
            logic [3:0] nib;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                nib = 4'($urandom);
                if (nib == 4'hA) nib = 4'h3;
                bad_txn({nib, 4'($urandom)}, 1);
            end else if (r < 5 || wr_list.size() == 0) begin
                a = (r == 1) ? 11'h7FE + 11'($urandom_range(0, 1)) : 11'($urandom);
                wq.delete();
                repeat ($urandom_range(1, 4)) wq.push_back(8'($urandom));
                write_txn(a);
            end else begin
                a = 11'(wr_list[$urandom_range(0, wr_list.size() - 1)]);
                n = 1;
                while (n < 4 && vld[a + 11'(n)]) n++;
                read_txn(a, n);
            end
        end
        #200;
        check("final_scoreboard_empty", 8'(exp_q.size()), 8'd0);
        check("final_wr_done_outstanding", 8'(wr_pending), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
